controle_rodada: RTL
====================

CONTROLE_RODADA -- requirements
Module: controle_rodada

Interface
REQ-001 Parameter N_JOG, default 8, number of player slots (2..16).
REQ-002 Parameter TIMEOUT, default 1000, clock cycles allowed per turn before auto-pass (>=2).
REQ-003 Parameter MAX_RODADAS, default 10, maximum full night+day rounds (1..255).
REQ-004 Localparam JW = $clog2(N_JOG+1), width of the player index.
REQ-005 clock  in  1  system clock; all state updates occur on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 jogar  in  1  start request, level-sampled.
REQ-008 passa  in  1  one-cycle pulse; the current player ends the turn.
REQ-009 vivos  in  N_JOG  alive mask; bit i high = player i alive.
REQ-010 fim_jogo  in  1  win condition from the datapath, sampled only in FIM_FASE.
REQ-011 rst_global, zera_CS  out  1  datapath clears.
REQ-012 e_seed_reg  out  1  seed register load enable.
REQ-013 jogador  out  JW  index of the current player.
REQ-014 fase  out  1  0 = night, 1 = day.
REQ-015 turno_ativo  out  1  high while a player turn is open.
REQ-016 estouro  out  1  one-cycle pulse on turn timeout.
REQ-017 rodada  out  8  completed-round count.
REQ-018 fim  out  1  game over, level.
REQ-019 db_estado  out  5  state code; 5'b11111 for an illegal state.

Function
REQ-020 States and codes SHALL be: INICIAL=0, RESETA_TUDO=1, PREPARA_JOGO=2, ARMAZENA_JOGO=3, PREPARA_FASE=4, BUSCA=5, TURNO=6, PROXIMO=7, FIM_FASE=8, TROCA_FASE=9, FIM_JOGO=10; any other state SHALL go to INICIAL.
REQ-021 INICIAL->RESETA_TUDO if jogar; RESETA_TUDO->PREPARA_JOGO unconditionally.
REQ-022 PREPARA_JOGO->ARMAZENA_JOGO on passa; ARMAZENA_JOGO->PREPARA_FASE.
REQ-023 PREPARA_FASE SHALL load jogador=0 and go to BUSCA.
REQ-024 BUSCA, evaluated in priority order: jogador==N_JOG -> FIM_FASE; else if vivos[jogador] -> TURNO; else jogador+1 and stay in BUSCA (one slot per cycle).
REQ-025 TURNO SHALL count cycles from 0, with the counter cleared on entry.
REQ-026 TURNO on passa -> PROXIMO.
REQ-027 TURNO on counter==TIMEOUT-1 without passa -> PROXIMO, with estouro pulsed in that same cycle.
REQ-028 When passa and timeout coincide, passa SHALL win and estouro SHALL stay low.
REQ-029 PROXIMO SHALL increment jogador and go to BUSCA.
REQ-030 FIM_FASE -> FIM_JOGO if fim_jogo, or if fase==1 and rodada==MAX_RODADAS-1; otherwise -> TROCA_FASE.
REQ-031 TROCA_FASE SHALL toggle fase, increment rodada when leaving day, and go to PREPARA_FASE.
REQ-032 FIM_JOGO SHALL hold until jogar, then go to RESETA_TUDO.
REQ-033 Moore outputs:
- rst_global, zera_CS in INICIAL and RESETA_TUDO.
- e_seed_reg in ARMAZENA_JOGO.
- turno_ativo in TURNO.
- fim in FIM_JOGO.
REQ-034 RESETA_TUDO SHALL clear fase, rodada, jogador and the turn counter.
REQ-035 With vivos all zero, BUSCA SHALL scan N_JOG+1 cycles and then reach FIM_FASE without opening a turn.
REQ-036 A passa outside PREPARA_JOGO and TURNO SHALL be ignored.
REQ-037 Changes to vivos SHALL take effect at the next BUSCA evaluation only.

Reset
REQ-038 reset low SHALL immediately force INICIAL, from any state including mid-turn.
REQ-039 reset low SHALL clear jogador, fase, rodada, the turn counter, estouro, turno_ativo and fim to 0.
REQ-040 During reset, rst_global and zera_CS SHALL be 1 and db_estado SHALL be 0.

Verification
REQ-041 Scenario: N_JOG=4, vivos=4'b1111, jogar, then passa at each wait -> turns for jogador 0,1,2,3; FIM_FASE; fase becomes 1; rodada stays 0.
REQ-042 Scenario: vivos=4'b1010 -> only jogador 1 and 3 get turno_ativo; two-cycle BUSCA skips are visible on db_estado.
REQ-043 Scenario: TIMEOUT=5, no passa in TURNO -> estouro high exactly on cycle 5 of the turn; next state PROXIMO.
REQ-044 Scenario: passa on the timeout cycle -> estouro stays 0 and the turn advances once.
REQ-045 Scenario: MAX_RODADAS=2, always passa -> fim asserts after the second day's FIM_FASE with rodada=1; a later jogar restarts to RESETA_TUDO.
REQ-046 Scenario: reset low mid-TURNO with jogador=2 -> db_estado=0, jogador=0, turno_ativo=0 asynchronously.

Source files
------------

// File: rtl/controle_rodada.sv
// ============================================================================
// Module   : controle_rodada
// Purpose  : Round/turn sequencer for a multi-player night/day game. Walks the
//            alive players one at a time, opens a timed turn for each, flips
//            between night and day phases and counts completed rounds until
//            the datapath reports a win or the round limit is reached.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   jogar       in   start request (level)
//   passa       in   one-cycle pulse: current player ends the turn
//   vivos       in   alive mask, bit i = player i alive
//   fim_jogo    in   win condition, sampled only at the end of a phase
//   rst_global  out  datapath clear
//   zera_CS     out  datapath clear
//   e_seed_reg  out  seed register load enable
//   jogador     out  index of the current player
//   fase        out  0 = night, 1 = day
//   turno_ativo out  high while a player turn is open
//   estouro     out  one-cycle pulse when a turn times out
//   rodada      out  completed-round count
//   fim         out  game over (level)
//   db_estado   out  state code, 5'b11111 for an illegal state
// ============================================================================
`default_nettype none

module controle_rodada #(
    parameter int N_JOG       = 8,
    parameter int TIMEOUT     = 1000,
    parameter int MAX_RODADAS = 10,
    localparam int JW         = $clog2(N_JOG + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jogar,
    input  logic             passa,
    input  logic [N_JOG-1:0] vivos,
    input  logic             fim_jogo,
    output logic             rst_global,
    output logic             zera_CS,
    output logic             e_seed_reg,
    output logic [JW-1:0]    jogador,
    output logic             fase,
    output logic             turno_ativo,
    output logic             estouro,
    output logic [7:0]       rodada,
    output logic             fim,
    output logic [4:0]       db_estado
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        RESETA_TUDO   = 4'd1,
        PREPARA_JOGO  = 4'd2,
        ARMAZENA_JOGO = 4'd3,
        PREPARA_FASE  = 4'd4,
        BUSCA         = 4'd5,
        TURNO         = 4'd6,
        PROXIMO       = 4'd7,
        FIM_FASE      = 4'd8,
        TROCA_FASE    = 4'd9,
        FIM_JOGO      = 4'd10
    } estado_t;

    estado_t        estado;
    estado_t        prox;
    logic [CW-1:0]  contador;
    logic [N_JOG:0] vivos_ext;
    logic           vivo_atual;
    logic           fim_scan;
    logic           tempo_esgotado;
    logic           ultima_rodada;

    // Padding the mask with a dead slot at index N_JOG lets the index run up
    // to N_JOG without an out-of-range select; that slot is never a turn.
    assign vivos_ext      = {1'b0, vivos};
    assign vivo_atual     = vivos_ext[jogador];
    assign fim_scan       = (jogador == JW'(N_JOG));
    assign tempo_esgotado = (contador == CW'(TIMEOUT - 1));
    assign ultima_rodada  = fase && (rodada == 8'(MAX_RODADAS - 1));

    // Timeout pulse must be cleared by a coinciding passa in the same cycle,
    // so it is decoded from the live input rather than registered.
    assign estouro = (estado == TURNO) && tempo_esgotado && !passa;

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:       if (jogar) prox = RESETA_TUDO;
            RESETA_TUDO:   prox = PREPARA_JOGO;
            PREPARA_JOGO:  if (passa) prox = ARMAZENA_JOGO;
            ARMAZENA_JOGO: prox = PREPARA_FASE;
            PREPARA_FASE:  prox = BUSCA;
            BUSCA: begin
                if (fim_scan)        prox = FIM_FASE;
                else if (vivo_atual) prox = TURNO;
            end
            TURNO:         if (passa || tempo_esgotado) prox = PROXIMO;
            PROXIMO:       prox = BUSCA;
            FIM_FASE:      prox = (fim_jogo || ultima_rodada) ? FIM_JOGO : TROCA_FASE;
            TROCA_FASE:    prox = PREPARA_FASE;
            FIM_JOGO:      if (jogar) prox = RESETA_TUDO;
            default:       prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= INICIAL;
            jogador     <= '0;
            fase        <= 1'b0;
            rodada      <= 8'd0;
            contador    <= '0;
            rst_global  <= 1'b1;
            zera_CS     <= 1'b1;
            e_seed_reg  <= 1'b0;
            turno_ativo <= 1'b0;
            fim         <= 1'b0;
        end else begin
            estado <= prox;

            // Moore flags are decoded from the next state so they line up
            // with the state register without a combinational output path.
            rst_global  <= (prox == INICIAL) || (prox == RESETA_TUDO);
            zera_CS     <= (prox == INICIAL) || (prox == RESETA_TUDO);
            e_seed_reg  <= (prox == ARMAZENA_JOGO);
            turno_ativo <= (prox == TURNO);
            fim         <= (prox == FIM_JOGO);

            case (estado)
                RESETA_TUDO: begin
                    fase     <= 1'b0;
                    rodada   <= 8'd0;
                    jogador  <= '0;
                    contador <= '0;
                end
                PREPARA_FASE: jogador <= '0;
                BUSCA: begin
                    if (!fim_scan && !vivo_atual) jogador <= jogador + JW'(1);
                    if (prox == TURNO)            contador <= '0;
                end
                TURNO:   contador <= contador + CW'(1);
                PROXIMO: jogador  <= jogador + JW'(1);
                TROCA_FASE: begin
                    fase <= ~fase;
                    if (fase) rodada <= rodada + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        db_estado = 5'b11111;
        case (estado)
            INICIAL, RESETA_TUDO, PREPARA_JOGO, ARMAZENA_JOGO, PREPARA_FASE,
            BUSCA, TURNO, PROXIMO, FIM_FASE, TROCA_FASE, FIM_JOGO:
                db_estado = {1'b0, estado};
            default: db_estado = 5'b11111;
        endcase
    end

endmodule

`default_nettype wire
